// File: rtl/block_mac_pkg.sv
// Shared types and tables for the 2x2 block multiply-accumulate engine.
package block_mac_pkg;

  localparam int unsigned IDX_W  = 3;
  localparam int unsigned TAG_W  = 2;
  localparam int unsigned N_PROD = 8;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Accumulator and operand positions within a 2x2 block
  localparam tag_t ACC_11 = 2'd0;
  localparam tag_t ACC_12 = 2'd1;
  localparam tag_t ACC_21 = 2'd2;
  localparam tag_t ACC_22 = 2'd3;

  typedef struct packed {
    tag_t a_sel;
    tag_t b_sel;
  } prod_sel_t;

  // Operand pair feeding product idx; two consecutive products share one accumulator
  function automatic prod_sel_t prod_sel(input idx_t idx);
    prod_sel_t s;
    case (idx)
      3'd0:    s = '{a_sel: ACC_11, b_sel: ACC_11};
      3'd1:    s = '{a_sel: ACC_12, b_sel: ACC_21};
      3'd2:    s = '{a_sel: ACC_11, b_sel: ACC_12};
      3'd3:    s = '{a_sel: ACC_12, b_sel: ACC_22};
      3'd4:    s = '{a_sel: ACC_21, b_sel: ACC_11};
      3'd5:    s = '{a_sel: ACC_22, b_sel: ACC_21};
      3'd6:    s = '{a_sel: ACC_21, b_sel: ACC_12};
      default: s = '{a_sel: ACC_22, b_sel: ACC_22};
    endcase
    return s;
  endfunction

  // Target accumulator of product idx
  function automatic tag_t acc_of(input idx_t idx);
    return idx[2:1];
  endfunction

endpackage

// File: rtl/block_mac_2x2_if.sv
// Control-unit <-> MAC engine job interface.
interface block_mac_2x2_if #(
  parameter int unsigned data_w = 32
);
  logic              start_mac;
  logic              clear_acc;
  logic [data_w-1:0] a_11, a_12, a_21, a_22;
  logic [data_w-1:0] b_11, b_12, b_21, b_22;
  logic [data_w-1:0] c_11, c_12, c_21, c_22;
  logic              done_mac;
  logic              busy;

  modport master (
    output start_mac, clear_acc,
    output a_11, a_12, a_21, a_22,
    output b_11, b_12, b_21, b_22,
    input  c_11, c_12, c_21, c_22,
    input  done_mac, busy
  );

  modport slave (
    input  start_mac, clear_acc,
    input  a_11, a_12, a_21, a_22,
    input  b_11, b_12, b_21, b_22,
    output c_11, c_12, c_21, c_22,
    output done_mac, busy
  );
endinterface

// File: rtl/mac_mul_pipe.sv
// Pipelined truncating multiplier carrying a valid bit and accumulator tag.
module mac_mul_pipe
  import block_mac_pkg::*;
#(
  parameter int unsigned data_w  = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_vld,
  input  tag_t               in_tag,
  input  logic [data_w-1:0]  in_a,
  input  logic [data_w-1:0]  in_b,
  output logic               out_vld,
  output tag_t               out_tag,
  output logic [data_w-1:0]  out_p,
  output logic [MUL_LAT-1:0] stage_vld
);

  logic [data_w-1:0]  p_q   [MUL_LAT];
  tag_t               tag_q [MUL_LAT];
  logic [MUL_LAT-1:0] vld_q;
  logic [data_w-1:0]  prod_c;

  // Low data_w bits of the product; same for signed and unsigned operands
  assign prod_c = in_a * in_b;

  // Valid chain, cleared by reset so an aborted job leaves nothing in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_vld;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Product and tag stages; qualified by the valid chain so no reset needed
  always_ff @(posedge clk) begin
    p_q[0]   <= prod_c;
    tag_q[0] <= in_tag;
    for (int i = 1; i < int'(MUL_LAT); i++) begin
      p_q[i]   <= p_q[i-1];
      tag_q[i] <= tag_q[i-1];
    end
  end

  assign out_vld   = vld_q[MUL_LAT-1];
  assign out_tag   = tag_q[MUL_LAT-1];
  assign out_p     = p_q[MUL_LAT-1];
  assign stage_vld = vld_q;

endmodule

// File: rtl/block_mac_2x2.sv
// 2x2 block C += A*B engine sharing one pipelined multiplier across eight products.
module block_mac_2x2
  import block_mac_pkg::*;
#(
  parameter int unsigned data_w  = 32,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  block_mac_2x2_if.slave bus
);

  // Output stage of the pipe; a product there is being added this cycle
  localparam logic [MUL_LAT-1:0] OUT_STAGE = MUL_LAT'(1) << (MUL_LAT - 1);

  state_t             state_q, state_n;
  idx_t               idx_q;
  logic [data_w-1:0]  a_q   [4];
  logic [data_w-1:0]  b_q   [4];
  logic [data_w-1:0]  acc_q [4];
  logic               done_q, busy_q;

  logic               accept_c;
  logic               issue_c;
  prod_sel_t          sel_c;
  logic               mul_vld;
  tag_t               mul_tag;
  logic [data_w-1:0]  mul_p;
  logic [MUL_LAT-1:0] mul_stage_vld;

  assign accept_c = (state_q == S_IDLE) && bus.start_mac;
  assign issue_c  = (state_q == S_ISSUE);
  assign sel_c    = prod_sel(idx_q);

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_n;
  end

  // Next-state logic; DONE is entered once only the final add remains in the pipe
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (bus.start_mac) state_n = S_ISSUE;
      S_ISSUE: if (idx_q == idx_t'(N_PROD - 1)) state_n = S_DRAIN;
      S_DRAIN: if ((mul_stage_vld & ~OUT_STAGE) == '0) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Registered status outputs derived from the upcoming state
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= (state_n == S_DONE);
      busy_q <= (state_n != S_IDLE);
    end
  end

  // Issue index walks the product table during ISSUE
  always_ff @(posedge clk) begin
    if (!rst)         idx_q <= '0;
    else if (issue_c) idx_q <= idx_q + idx_t'(1);
    else              idx_q <= '0;
  end

  // Operand latch; later bus changes do not disturb the running job
  always_ff @(posedge clk) begin
    if (accept_c) begin
      a_q[ACC_11] <= bus.a_11;
      a_q[ACC_12] <= bus.a_12;
      a_q[ACC_21] <= bus.a_21;
      a_q[ACC_22] <= bus.a_22;
      b_q[ACC_11] <= bus.b_11;
      b_q[ACC_12] <= bus.b_12;
      b_q[ACC_21] <= bus.b_21;
      b_q[ACC_22] <= bus.b_22;
    end
  end

  mac_mul_pipe #(
    .data_w  (data_w),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (issue_c),
    .in_tag    (acc_of(idx_q)),
    .in_a      (a_q[sel_c.a_sel]),
    .in_b      (b_q[sel_c.b_sel]),
    .out_vld   (mul_vld),
    .out_tag   (mul_tag),
    .out_p     (mul_p),
    .stage_vld (mul_stage_vld)
  );

  // Accumulators: optional clear on accept, then one wrapping add per product
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else if (accept_c && bus.clear_acc) begin
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else if (mul_vld) begin
      acc_q[mul_tag] <= acc_q[mul_tag] + mul_p;
    end
  end

  assign bus.c_11     = acc_q[ACC_11];
  assign bus.c_12     = acc_q[ACC_12];
  assign bus.c_21     = acc_q[ACC_21];
  assign bus.c_22     = acc_q[ACC_22];
  assign bus.done_mac = done_q;
  assign bus.busy     = busy_q;

endmodule
